// File: rtl/id_ex_pipeline_reg_pkg.sv
// Shared definitions for the ID/EX pipeline register: default widths,
// forwarding select codes and small bubble-decision helpers.
package id_ex_pipeline_reg_pkg;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_REG_ADDR_W = 5;
    localparam int DEF_ALUOP_W    = 4;
    localparam int DEF_CNT_W      = 16;

    typedef enum logic [1:0] {
        FWD_REG   = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10,
        FWD_IMM   = 2'b11
    } fwd_sel_e;

    // Any of these turns the EX slot into an empty bubble.
    function automatic logic needs_bubble(input logic flush, input logic stall, input logic valid);
        return flush | stall | ~valid;
    endfunction

    // Only a load-use stall that is not also being flushed counts as a hazard bubble.
    function automatic logic counts_bubble(input logic flush, input logic stall);
        return stall & ~flush;
    endfunction

endpackage

// File: rtl/id_ex_pipeline_reg_if.sv
// ID-stage inputs and EX-stage outputs of the ID/EX pipeline register.
// The master side is the decode/hazard logic, the slave side is the register.
interface id_ex_pipeline_reg_if
    import id_ex_pipeline_reg_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int ALUOP_W    = DEF_ALUOP_W,
    parameter int CNT_W      = DEF_CNT_W
);
    logic                  Stall_ID;
    logic                  Flush_EX;
    logic                  Valid_ID;
    logic [DATA_W-1:0]     Rs_Val_ID;
    logic [DATA_W-1:0]     Rt_Val_ID;
    logic [DATA_W-1:0]     Imm_ID;
    logic [REG_ADDR_W-1:0] Rw_ID;
    logic                  RegWr_ID;
    logic                  MemRd_ID;
    logic                  MemWr_ID;
    logic [ALUOP_W-1:0]    ALU_OP_ID;
    logic [1:0]            OP_A_SEL;
    logic [1:0]            OP_B_SEL;
    logic [DATA_W-1:0]     ALU_Res_EX_MEM;
    logic [DATA_W-1:0]     WB_Data_MEM_WB;
    logic [DATA_W-1:0]     Op_A_EX;
    logic [DATA_W-1:0]     Op_B_EX;
    logic [DATA_W-1:0]     Store_Data_EX;
    logic [REG_ADDR_W-1:0] Rw_ID_EX;
    logic                  LD_ID_EX;
    logic                  RegWr_EX;
    logic                  MemWr_EX;
    logic [ALUOP_W-1:0]    ALU_OP_EX;
    logic                  Valid_EX;
    logic [CNT_W-1:0]      Bubble_Cnt;

    modport master (
        output Stall_ID, Flush_EX, Valid_ID, Rs_Val_ID, Rt_Val_ID, Imm_ID, Rw_ID,
               RegWr_ID, MemRd_ID, MemWr_ID, ALU_OP_ID, OP_A_SEL, OP_B_SEL,
               ALU_Res_EX_MEM, WB_Data_MEM_WB,
        input  Op_A_EX, Op_B_EX, Store_Data_EX, Rw_ID_EX, LD_ID_EX, RegWr_EX,
               MemWr_EX, ALU_OP_EX, Valid_EX, Bubble_Cnt
    );

    modport slave (
        input  Stall_ID, Flush_EX, Valid_ID, Rs_Val_ID, Rt_Val_ID, Imm_ID, Rw_ID,
               RegWr_ID, MemRd_ID, MemWr_ID, ALU_OP_ID, OP_A_SEL, OP_B_SEL,
               ALU_Res_EX_MEM, WB_Data_MEM_WB,
        output Op_A_EX, Op_B_EX, Store_Data_EX, Rw_ID_EX, LD_ID_EX, RegWr_EX,
               MemWr_EX, ALU_OP_EX, Valid_EX, Bubble_Cnt
    );
endinterface

// File: rtl/id_ex_pipeline_reg_fwd_operand_mux.sv
// 4:1 EX operand select between the registered value, the two forward
// sources and the immediate. Without IMM_OK the immediate code falls back to the register.
module fwd_operand_mux
    import id_ex_pipeline_reg_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter bit IMM_OK = 1'b0
) (
    input  logic [1:0]        sel,
    input  logic [DATA_W-1:0] reg_val,
    input  logic [DATA_W-1:0] exmem_val,
    input  logic [DATA_W-1:0] memwb_val,
    input  logic [DATA_W-1:0] imm_val,
    output logic [DATA_W-1:0] operand
);

    // Operand selection from the registered select code.
    always_comb begin
        operand = reg_val;
        case (sel)
            FWD_REG:   operand = reg_val;
            FWD_EXMEM: operand = exmem_val;
            FWD_MEMWB: operand = memwb_val;
            FWD_IMM: begin
                if (IMM_OK) begin
                    operand = imm_val;
                end else begin
                    operand = reg_val;
                end
            end
            default:   operand = reg_val;
        endcase
    end

endmodule

// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register: captures decoded fields, inserts bubbles on
// stall/flush/empty slots, drives the EX operand muxes and counts hazard bubbles.
module id_ex_pipeline_reg
    import id_ex_pipeline_reg_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int ALUOP_W    = DEF_ALUOP_W,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    id_ex_pipeline_reg_if.slave  bus
);

    logic                  bubble_s;
    logic                  cnt_inc_s;
    logic [DATA_W-1:0]     op_a_s;
    logic [DATA_W-1:0]     op_b_s;
    logic [DATA_W-1:0]     rs_val_r;
    logic [DATA_W-1:0]     rt_val_r;
    logic [DATA_W-1:0]     imm_r;
    logic [REG_ADDR_W-1:0] rw_r;
    logic                  regwr_r;
    logic                  memrd_r;
    logic                  memwr_r;
    logic [ALUOP_W-1:0]    aluop_r;
    logic                  valid_r;
    logic [1:0]            SelA_q;
    logic [1:0]            SelB_q;
    logic [CNT_W-1:0]      bubble_cnt_r;

    assign bubble_s  = needs_bubble(bus.Flush_EX, bus.Stall_ID, bus.Valid_ID);
    assign cnt_inc_s = counts_bubble(bus.Flush_EX, bus.Stall_ID);

    // Pipeline register bank: never holds; a bubble clears every field.
    always_ff @(posedge clk) begin
        if (reset || bubble_s) begin
            rs_val_r <= {DATA_W{1'b0}};
            rt_val_r <= {DATA_W{1'b0}};
            imm_r    <= {DATA_W{1'b0}};
            rw_r     <= {REG_ADDR_W{1'b0}};
            regwr_r  <= 1'b0;
            memrd_r  <= 1'b0;
            memwr_r  <= 1'b0;
            aluop_r  <= {ALUOP_W{1'b0}};
            valid_r  <= 1'b0;
            SelA_q   <= 2'b00;
            SelB_q   <= 2'b00;
        end else begin
            rs_val_r <= bus.Rs_Val_ID;
            rt_val_r <= bus.Rt_Val_ID;
            imm_r    <= bus.Imm_ID;
            rw_r     <= bus.Rw_ID;
            // Register 0 is hard-wired, so a write to it is dropped here.
            regwr_r  <= bus.RegWr_ID & (bus.Rw_ID != {REG_ADDR_W{1'b0}});
            memrd_r  <= bus.MemRd_ID;
            memwr_r  <= bus.MemWr_ID;
            aluop_r  <= bus.ALU_OP_ID;
            valid_r  <= 1'b1;
            SelA_q   <= bus.OP_A_SEL;
            SelB_q   <= bus.OP_B_SEL;
        end
    end

    // Saturating hazard-bubble counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_inc_s && (bubble_cnt_r != {CNT_W{1'b1}})) begin
            bubble_cnt_r <= bubble_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            bubble_cnt_r <= bubble_cnt_r;
        end
    end

    fwd_operand_mux #(.DATA_W(DATA_W), .IMM_OK(1'b0)) u_mux_a (
        .sel       (SelA_q),
        .reg_val   (rs_val_r),
        .exmem_val (bus.ALU_Res_EX_MEM),
        .memwb_val (bus.WB_Data_MEM_WB),
        .imm_val   (imm_r),
        .operand   (op_a_s)
    );

    fwd_operand_mux #(.DATA_W(DATA_W), .IMM_OK(1'b1)) u_mux_b (
        .sel       (SelB_q),
        .reg_val   (rt_val_r),
        .exmem_val (bus.ALU_Res_EX_MEM),
        .memwb_val (bus.WB_Data_MEM_WB),
        .imm_val   (imm_r),
        .operand   (op_b_s)
    );

    assign bus.Op_A_EX       = op_a_s;
    assign bus.Op_B_EX       = op_b_s;
    assign bus.Store_Data_EX = rt_val_r;
    assign bus.Rw_ID_EX      = rw_r;
    assign bus.LD_ID_EX      = memrd_r;
    assign bus.RegWr_EX      = regwr_r;
    assign bus.MemWr_EX      = memwr_r;
    assign bus.ALU_OP_EX     = aluop_r;
    assign bus.Valid_EX      = valid_r;
    assign bus.Bubble_Cnt    = bubble_cnt_r;

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Self-checking bench for id_ex_pipeline_reg: directed scenarios plus a
// randomized run against a slot-level reference model.
module tb_id_ex_pipeline_reg;

    typedef struct packed {
        logic        valid;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] imm;
        logic [4:0]  rw;
        logic        regwr;
        logic        ld;
        logic        memwr;
        logic [3:0]  aluop;
        logic [1:0]  sa;
        logic [1:0]  sb;
    } slot_t;

    logic clk;
    logic reset;
    int   n_total;
    int   n_pass;
    slot_t       m;
    int unsigned m_cnt;

    id_ex_pipeline_reg_if bus_i ();

    id_ex_pipeline_reg dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected EX operand from the select rules (code 3 is an immediate only on B).
    function automatic logic [31:0] exp_op(input logic [1:0] sel, input logic [31:0] regv,
                                           input logic [31:0] imm, input bit is_b);
        case (sel)
            2'd1:    return bus_i.ALU_Res_EX_MEM;
            2'd2:    return bus_i.WB_Data_MEM_WB;
            2'd3:    return is_b ? imm : regv;
            default: return regv;
        endcase
    endfunction

    // One clock edge; the model advances using the inputs present at the edge.
    task automatic tick();
        slot_t nxt;
        nxt = '0;
        if (!reset && !bus_i.Flush_EX && !bus_i.Stall_ID && bus_i.Valid_ID) begin
            nxt.valid = 1'b1;
            nxt.rs    = bus_i.Rs_Val_ID;
            nxt.rt    = bus_i.Rt_Val_ID;
            nxt.imm   = bus_i.Imm_ID;
            nxt.rw    = bus_i.Rw_ID;
            nxt.regwr = bus_i.RegWr_ID && (bus_i.Rw_ID != 5'd0);
            nxt.ld    = bus_i.MemRd_ID;
            nxt.memwr = bus_i.MemWr_ID;
            nxt.aluop = bus_i.ALU_OP_ID;
            nxt.sa    = bus_i.OP_A_SEL;
            nxt.sb    = bus_i.OP_B_SEL;
        end
        if (reset) m_cnt = 0;
        else if (bus_i.Stall_ID && !bus_i.Flush_EX && m_cnt < 65535) m_cnt = m_cnt + 1;
        @(posedge clk);
        #1;
        m = nxt;
    endtask

    task automatic drive_idle();
        bus_i.Stall_ID = 1'b0;       bus_i.Flush_EX = 1'b0;   bus_i.Valid_ID = 1'b0;
        bus_i.Rs_Val_ID = 32'd0;     bus_i.Rt_Val_ID = 32'd0; bus_i.Imm_ID = 32'd0;
        bus_i.Rw_ID = 5'd0;          bus_i.RegWr_ID = 1'b0;   bus_i.MemRd_ID = 1'b0;
        bus_i.MemWr_ID = 1'b0;       bus_i.ALU_OP_ID = 4'd0;  bus_i.OP_A_SEL = 2'd0;
        bus_i.OP_B_SEL = 2'd0;       bus_i.ALU_Res_EX_MEM = 32'd0;
        bus_i.WB_Data_MEM_WB = 32'd0;
    endtask

    task automatic test_reset();
        drive_idle();
        bus_i.ALU_Res_EX_MEM = 32'h1234_5678;
        bus_i.WB_Data_MEM_WB = 32'h9abc_def0;
        reset = 1'b1;
        tick();
        tick();
        n_total += 5;
        if (bus_i.Valid_EX !== 1'b0) $display("FAIL reset_valid: got %0h expected 0", bus_i.Valid_EX); else n_pass++;
        if (bus_i.Rw_ID_EX !== 5'd0) $display("FAIL reset_rw: got %0h expected 0", bus_i.Rw_ID_EX); else n_pass++;
        if (bus_i.LD_ID_EX !== 1'b0) $display("FAIL reset_ld: got %0h expected 0", bus_i.LD_ID_EX); else n_pass++;
        if (bus_i.Bubble_Cnt !== 16'd0) $display("FAIL reset_cnt: got %0h expected 0", bus_i.Bubble_Cnt); else n_pass++;
        if (bus_i.Op_A_EX !== 32'd0) $display("FAIL reset_opa: got %0h expected 0", bus_i.Op_A_EX); else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_normal_load();
        bus_i.Valid_ID = 1'b1;  bus_i.Rs_Val_ID = 32'd5; bus_i.Imm_ID = 32'd9;
        bus_i.Rt_Val_ID = 32'd7; bus_i.Rw_ID = 5'd3;     bus_i.RegWr_ID = 1'b1;
        bus_i.OP_A_SEL = 2'b00; bus_i.OP_B_SEL = 2'b11;
        tick();
        n_total += 6;
        if (bus_i.Op_A_EX !== 32'd5) $display("FAIL load_opa: got %0h expected 5", bus_i.Op_A_EX); else n_pass++;
        if (bus_i.Op_B_EX !== 32'd9) $display("FAIL load_opb: got %0h expected 9", bus_i.Op_B_EX); else n_pass++;
        if (bus_i.Rw_ID_EX !== 5'd3) $display("FAIL load_rw: got %0h expected 3", bus_i.Rw_ID_EX); else n_pass++;
        if (bus_i.RegWr_EX !== 1'b1) $display("FAIL load_regwr: got %0h expected 1", bus_i.RegWr_EX); else n_pass++;
        if (bus_i.Valid_EX !== 1'b1) $display("FAIL load_valid: got %0h expected 1", bus_i.Valid_EX); else n_pass++;
        if (bus_i.Store_Data_EX !== 32'd7) $display("FAIL load_store: got %0h expected 7", bus_i.Store_Data_EX); else n_pass++;
    endtask

    task automatic test_forward();
        bus_i.OP_A_SEL = 2'b01; bus_i.OP_B_SEL = 2'b10;
        bus_i.ALU_Res_EX_MEM = 32'hAA; bus_i.WB_Data_MEM_WB = 32'hBB;
        tick();
        n_total += 3;
        if (bus_i.Op_A_EX !== 32'hAA) $display("FAIL fwd_opa: got %0h expected aa", bus_i.Op_A_EX); else n_pass++;
        if (bus_i.Op_B_EX !== 32'hBB) $display("FAIL fwd_opb: got %0h expected bb", bus_i.Op_B_EX); else n_pass++;
        bus_i.ALU_Res_EX_MEM = 32'hCC;
        #1;
        if (bus_i.Op_A_EX !== 32'hCC) $display("FAIL fwd_live: got %0h expected cc", bus_i.Op_A_EX); else n_pass++;
    endtask

    task automatic test_load_use();
        bus_i.MemRd_ID = 1'b1;
        tick();
        n_total += 4;
        if (bus_i.LD_ID_EX !== 1'b1) $display("FAIL lu_ld: got %0h expected 1", bus_i.LD_ID_EX); else n_pass++;
        bus_i.MemRd_ID = 1'b0;
        bus_i.Stall_ID = 1'b1;
        tick();
        bus_i.Stall_ID = 1'b0;
        if (bus_i.Valid_EX !== 1'b0) $display("FAIL lu_valid: got %0h expected 0", bus_i.Valid_EX); else n_pass++;
        if (bus_i.LD_ID_EX !== 1'b0) $display("FAIL lu_ld_bubble: got %0h expected 0", bus_i.LD_ID_EX); else n_pass++;
        if (bus_i.Bubble_Cnt !== 16'd1) $display("FAIL lu_cnt: got %0h expected 1", bus_i.Bubble_Cnt); else n_pass++;
    endtask

    task automatic test_flush_stall();
        bus_i.Flush_EX = 1'b1; bus_i.Stall_ID = 1'b1;
        tick();
        bus_i.Flush_EX = 1'b0; bus_i.Stall_ID = 1'b0;
        n_total += 4;
        if (bus_i.Valid_EX !== 1'b0) $display("FAIL fs_valid: got %0h expected 0", bus_i.Valid_EX); else n_pass++;
        if (bus_i.Bubble_Cnt !== 16'd1) $display("FAIL fs_cnt: got %0h expected 1", bus_i.Bubble_Cnt); else n_pass++;
        bus_i.Rw_ID = 5'd0; bus_i.RegWr_ID = 1'b1;
        tick();
        if (bus_i.RegWr_EX !== 1'b0) $display("FAIL r0_regwr: got %0h expected 0", bus_i.RegWr_EX); else n_pass++;
        if (bus_i.Valid_EX !== 1'b1) $display("FAIL r0_valid: got %0h expected 1", bus_i.Valid_EX); else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset                = ($urandom_range(0, 49) == 0);
            bus_i.Stall_ID       = ($urandom_range(0, 3) == 0);
            bus_i.Flush_EX       = ($urandom_range(0, 7) == 0);
            bus_i.Valid_ID       = ($urandom_range(0, 7) != 0);
            bus_i.Rs_Val_ID      = $urandom;
            bus_i.Rt_Val_ID      = $urandom;
            bus_i.Imm_ID         = $urandom;
            bus_i.Rw_ID          = 5'($urandom_range(0, 31));
            bus_i.RegWr_ID       = 1'($urandom_range(0, 1));
            bus_i.MemRd_ID       = 1'($urandom_range(0, 1));
            bus_i.MemWr_ID       = 1'($urandom_range(0, 1));
            bus_i.ALU_OP_ID      = 4'($urandom_range(0, 15));
            bus_i.OP_A_SEL       = 2'($urandom_range(0, 3));
            bus_i.OP_B_SEL       = 2'($urandom_range(0, 3));
            bus_i.ALU_Res_EX_MEM = $urandom;
            bus_i.WB_Data_MEM_WB = $urandom;
            tick();
            bus_i.ALU_Res_EX_MEM = $urandom;
            bus_i.WB_Data_MEM_WB = $urandom;
            #1;
            n_total += 10;
            if (bus_i.Valid_EX !== m.valid) $display("FAIL rnd_valid[%0d]: got %0h expected %0h", i, bus_i.Valid_EX, m.valid); else n_pass++;
            if (bus_i.Op_A_EX !== exp_op(m.sa, m.rs, m.imm, 1'b0)) $display("FAIL rnd_opa[%0d]: got %0h expected %0h", i, bus_i.Op_A_EX, exp_op(m.sa, m.rs, m.imm, 1'b0)); else n_pass++;
            if (bus_i.Op_B_EX !== exp_op(m.sb, m.rt, m.imm, 1'b1)) $display("FAIL rnd_opb[%0d]: got %0h expected %0h", i, bus_i.Op_B_EX, exp_op(m.sb, m.rt, m.imm, 1'b1)); else n_pass++;
            if (bus_i.Store_Data_EX !== m.rt) $display("FAIL rnd_store[%0d]: got %0h expected %0h", i, bus_i.Store_Data_EX, m.rt); else n_pass++;
            if (bus_i.Rw_ID_EX !== m.rw) $display("FAIL rnd_rw[%0d]: got %0h expected %0h", i, bus_i.Rw_ID_EX, m.rw); else n_pass++;
            if (bus_i.LD_ID_EX !== m.ld) $display("FAIL rnd_ld[%0d]: got %0h expected %0h", i, bus_i.LD_ID_EX, m.ld); else n_pass++;
            if (bus_i.RegWr_EX !== m.regwr) $display("FAIL rnd_regwr[%0d]: got %0h expected %0h", i, bus_i.RegWr_EX, m.regwr); else n_pass++;
            if (bus_i.MemWr_EX !== m.memwr) $display("FAIL rnd_memwr[%0d]: got %0h expected %0h", i, bus_i.MemWr_EX, m.memwr); else n_pass++;
            if (bus_i.ALU_OP_EX !== m.aluop) $display("FAIL rnd_aluop[%0d]: got %0h expected %0h", i, bus_i.ALU_OP_EX, m.aluop); else n_pass++;
            if (bus_i.Bubble_Cnt !== 16'(m_cnt)) $display("FAIL rnd_cnt[%0d]: got %0h expected %0h", i, bus_i.Bubble_Cnt, m_cnt); else n_pass++;
        end
        reset = 1'b0;
    endtask

    task automatic test_saturation();
        drive_idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus_i.Stall_ID = 1'b1;
        for (int i = 0; i < 65535; i++) tick();
        n_total += 5;
        if (bus_i.Bubble_Cnt !== 16'hFFFF) $display("FAIL sat_full: got %0h expected ffff", bus_i.Bubble_Cnt); else n_pass++;
        tick();
        if (bus_i.Bubble_Cnt !== 16'hFFFF) $display("FAIL sat_hold: got %0h expected ffff", bus_i.Bubble_Cnt); else n_pass++;
        bus_i.Stall_ID = 1'b0; bus_i.Valid_ID = 1'b1; bus_i.Rw_ID = 5'd9; bus_i.RegWr_ID = 1'b1;
        tick();
        if (bus_i.Valid_EX !== 1'b1) $display("FAIL mid_valid_pre: got %0h expected 1", bus_i.Valid_EX); else n_pass++;
        bus_i.Stall_ID = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        if (bus_i.Bubble_Cnt !== 16'd0) $display("FAIL mid_reset_cnt: got %0h expected 0", bus_i.Bubble_Cnt); else n_pass++;
        if (bus_i.Valid_EX !== 1'b0) $display("FAIL mid_reset_valid: got %0h expected 0", bus_i.Valid_EX); else n_pass++;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        m       = '0;
        m_cnt   = 0;
        reset   = 1'b1;
        drive_idle();
        test_reset();
        test_normal_load();
        test_forward();
        test_load_use();
        test_flush_stall();
        test_random();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
